// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package : fp_pkg
// Purpose : Shared IEEE-754 single-precision definitions for the FP datapath
//           (float-to-int, int-to-float and friends).
// Contents: fp32_t field view, exponent constants, int32 saturation limits,
//           float-to-int classification and stage-1 payload types.
// Revision: 1.0  initial release
// ============================================================================
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;

    // Operand class as decided by the unpack stage.
    typedef enum logic [1:0] {
        CLS_NUM = 2'd0,   // finite value, magnitude/guard/sticky meaningful
        CLS_NAN = 2'd1,
        CLS_INF = 2'd2,
        CLS_OVF = 2'd3    // finite but certainly beyond int32 range
    } f2i_class_t;

    // Payload carried from the unpack/shift stage to the round stage.
    typedef struct packed {
        logic        sign;
        f2i_class_t  cls;
        logic [31:0] mag;      // truncated integer magnitude
        logic        guard;    // first discarded fraction bit (weight 1/2)
        logic        sticky;   // OR of all discarded bits below guard
    } f2i_s1_t;

endpackage
`default_nettype wire

// File: rtl/fp_rshift_sticky.sv
`default_nettype none
// ============================================================================
// Module  : fp_rshift_sticky
// Purpose : Right-shifts a 24-bit significand by 0..24 positions, keeping one
//           guard position below the binary point and a sticky OR of the rest.
// Ports   : i_val    [23:0] significand
//           i_shamt  [4:0]  shift amount, 0..24
//           o_val    [23:0] integer part after the shift
//           o_guard         bit just below the binary point
//           o_sticky        OR of every bit below the guard bit
// Revision: 1.0  initial release
// ============================================================================
module fp_rshift_sticky (
    input  logic [23:0] i_val,
    input  logic [4:0]  i_shamt,
    output logic [23:0] o_val,
    output logic        o_guard,
    output logic        o_sticky
);

    // The low 24 zero bits catch everything shifted out, so a shift of 24
    // still leaves the leading bit visible in the guard position.
    logic [47:0] w_ext;

    assign w_ext    = {i_val, 24'b0} >> i_shamt;
    assign o_val    = w_ext[47:24];
    assign o_guard  = w_ext[23];
    assign o_sticky = |w_ext[22:0];

endmodule
`default_nettype wire

// File: rtl/float_to_signed_int_pipe.sv
`default_nettype none
// ============================================================================
// Module  : float_to_signed_int_pipe
// Purpose : Two-stage valid/ready pipeline converting IEEE-754 single values
//           to saturated 32-bit two's-complement integers with
//           overflow / invalid / inexact flags.
// Params  : ROUND_MODE  0 = truncate toward zero, 1 = nearest, ties to even
// Ports   : clk, rst (synchronous, active-high)
//           in_vld / in_rdy / FP_val[31:0]        input handshake and operand
//           out_vld / out_rdy / int_val[31:0]     output handshake and result
//           ovf, inv, inexact                     per-result flags
// Revision: 1.0  initial release
// ============================================================================
module float_to_signed_int_pipe
    import fp_pkg::*;
#(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [31:0] FP_val,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] int_val,
    output logic        ovf,
    output logic        inv,
    output logic        inexact
);

    // ------------------------------------------------------------------
    // Handshake: each stage advances when the stage after it is empty or
    // draining. in_rdy is therefore combinational from out_rdy.
    // ------------------------------------------------------------------
    logic        r_s1_vld;
    logic        r_s2_vld;
    f2i_s1_t     r_s1;
    logic [31:0] r_int_val;
    logic        r_ovf;
    logic        r_inv;
    logic        r_inexact;

    logic w_adv1;
    logic w_adv2;

    assign w_adv2 = ~r_s2_vld | out_rdy;
    assign w_adv1 = ~r_s1_vld | w_adv2;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, align to the binary point.
    // ------------------------------------------------------------------
    fp32_t              w_fp;
    logic signed [8:0]  w_e;
    logic [23:0]        w_mag24;
    logic [4:0]         w_shamt;
    logic [2:0]         w_lsh;
    logic [23:0]        w_rs_val;
    logic               w_rs_guard;
    logic               w_rs_sticky;
    f2i_s1_t            w_s1_d;

    assign w_fp    = fp32_t'(FP_val);
    assign w_e     = $signed({1'b0, w_fp.exp}) - $signed(9'(FP_BIAS));
    assign w_mag24 = {1'b1, w_fp.man};
    // 23 - e, valid for e in -1..23 (e = -1 wraps to 24 in 5 bits).
    assign w_shamt = 5'd23 - w_e[4:0];
    // e - 23, valid for e in 24..30.
    assign w_lsh   = w_e[2:0] + 3'd1;

    fp_rshift_sticky u_rshift (
        .i_val    (w_mag24),
        .i_shamt  (w_shamt),
        .o_val    (w_rs_val),
        .o_guard  (w_rs_guard),
        .o_sticky (w_rs_sticky)
    );

    always_comb begin
        w_s1_d      = '0;
        w_s1_d.sign = w_fp.sign;
        w_s1_d.cls  = CLS_NUM;
        if (w_fp.exp == 8'h00) begin
            // Zero or denormal: flushed to 0, flagged inexact if nonzero.
            w_s1_d.sticky = |w_fp.man;
        end else if (w_fp.exp == FP_EXP_MAX) begin
            w_s1_d.cls = (w_fp.man != '0) ? CLS_NAN : CLS_INF;
        end else if (w_e < -9'sd1) begin
            // Below one half: only the sticky bit survives.
            w_s1_d.sticky = 1'b1;
        end else if (w_e <= 9'sd23) begin
            w_s1_d.mag    = {8'b0, w_rs_val};
            w_s1_d.guard  = w_rs_guard;
            w_s1_d.sticky = w_rs_sticky;
        end else if (w_e <= 9'sd30) begin
            w_s1_d.mag = {8'b0, w_mag24} << w_lsh;
        end else if ((w_e == 9'sd31) && (w_fp.man == '0)) begin
            // Exactly 2^31: representable only when negative, decided later.
            w_s1_d.mag = INT32_MIN;
        end else begin
            w_s1_d.cls = CLS_OVF;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, apply sign, saturate.
    // ------------------------------------------------------------------
    logic        w_inc;
    logic [31:0] w_mag_r;
    logic        w_too_big;
    logic [31:0] w_res;
    logic        w_ovf;
    logic        w_inv;
    logic        w_inexact;

    assign w_inc     = (ROUND_MODE == 1) && r_s1.guard && (r_s1.sticky || r_s1.mag[0]);
    assign w_mag_r   = r_s1.mag + {31'b0, w_inc};
    // 2^31 fits only as -2^31; anything with bit 31 set beyond that does not.
    assign w_too_big = w_mag_r[31] && (!r_s1.sign || (|w_mag_r[30:0]));

    always_comb begin
        w_res     = '0;
        w_ovf     = 1'b0;
        w_inv     = 1'b0;
        w_inexact = 1'b0;
        if (r_s1.cls == CLS_NAN) begin
            w_res = INT32_MIN;
            w_inv = 1'b1;
        end else if ((r_s1.cls != CLS_NUM) || w_too_big) begin
            w_res = r_s1.sign ? INT32_MIN : INT32_MAX;
            w_ovf = 1'b1;
        end else begin
            w_res     = r_s1.sign ? (~w_mag_r + 32'd1) : w_mag_r;
            w_inexact = r_s1.guard | r_s1.sticky;
        end
    end

    // ------------------------------------------------------------------
    // Stage registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1      <= '0;
            r_s2_vld  <= 1'b0;
            r_int_val <= '0;
            r_ovf     <= 1'b0;
            r_inv     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_vld <= in_vld;
                if (in_vld) begin
                    r_s1 <= w_s1_d;
                end
            end
            if (w_adv2) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_int_val <= w_res;
                    r_ovf     <= w_ovf;
                    r_inv     <= w_inv;
                    r_inexact <= w_inexact;
                end
            end
        end
    end

    assign in_rdy  = w_adv1;
    assign out_vld = r_s2_vld;
    assign int_val = r_int_val;
    assign ovf     = r_ovf;
    assign inv     = r_inv;
    assign inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_float_to_signed_int_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_float_to_signed_int_pipe
// Purpose : Scoreboard bench for float_to_signed_int_pipe. Two instances
//           (truncate and round-to-nearest-even) share one stimulus stream;
//           expected results come from an arithmetic reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_float_to_signed_int_pipe;

    localparam logic [31:0] C_MIN = 32'h8000_0000;
    localparam logic [31:0] C_MAX = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [31:0] fp_val;
    logic        out_rdy;

    logic        in_rdy0, out_vld0, ovf0, inv0, inx0;
    logic        in_rdy1, out_vld1, ovf1, inv1, inx1;
    logic [31:0] iv0, iv1;

    int checks = 0;
    int errors = 0;

    // Each entry: {int_val[31:0], ovf, inv, inexact}
    logic [34:0] q0[$];
    logic [34:0] q1[$];

    bit          rand_rdy = 1'b0;
    bit          stall [2];
    logic [34:0] prev  [2];

    always #5 clk = ~clk;

    float_to_signed_int_pipe #(.ROUND_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy0), .FP_val(fp_val),
        .out_vld(out_vld0), .out_rdy(out_rdy), .int_val(iv0),
        .ovf(ovf0), .inv(inv0), .inexact(inx0)
    );

    float_to_signed_int_pipe #(.ROUND_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy1), .FP_val(fp_val),
        .out_vld(out_vld1), .out_rdy(out_rdy), .int_val(iv1),
        .ovf(ovf1), .inv(inv1), .inexact(inx1)
    );

    // Reference: value = 1.M * 2^e evaluated with integer arithmetic,
    // remainder compared against one half for rounding.
    function automatic logic [34:0] model(input logic [31:0] f, input int rm);
        logic   s;
        int     e;
        int     sh;
        longint m, q, rem, half;
        bit     big, inx;
        s   = f[31];
        q   = 0;
        inx = 1'b0;
        big = 1'b0;
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 0) return {C_MIN, 3'b010};
            return {(s ? C_MIN : C_MAX), 3'b100};
        end
        if (f[30:23] == 8'h00) begin
            inx = (f[22:0] != 0);
        end else begin
            e = int'(f[30:23]) - 127;
            m = longint'({1'b1, f[22:0]});
            if (e >= 23) begin
                if (e > 40) big = 1'b1;
                else        q = m << (e - 23);
            end else if (23 - e > 40) begin
                inx = 1'b1;
            end else begin
                sh   = 23 - e;
                q    = m >> sh;
                rem  = m - (q << sh);
                half = longint'(1) << (sh - 1);
                inx  = (rem != 0);
                if (rm == 1 && (rem > half || (rem == half && q[0]))) q = q + 1;
            end
        end
        if (big || (s ? (q > 64'sh8000_0000) : (q > 64'sh7FFF_FFFF)))
            return {(s ? C_MIN : C_MAX), 3'b100};
        if (s) q = -q;
        return {q[31:0], 2'b00, inx};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic mon(input int id, input logic vld, input logic [34:0] got);
        logic [34:0] e;
        if (rst) begin
            stall[id] = 1'b0;
            return;
        end
        if (stall[id]) begin
            chk($sformatf("stable%0d_vld", id), 64'(vld), 64'd1);
            chk($sformatf("stable%0d_data", id), 64'(got), 64'(prev[id]));
        end
        if (vld && out_rdy) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out%0d: got %h expected no output", id, got);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("result%0d", id), 64'(got), 64'(e));
            end
        end
        stall[id] = vld && !out_rdy;
        prev[id]  = got;
    endtask

    always @(negedge clk) begin
        mon(0, out_vld0, {iv0, ovf0, inv0, inx0});
        mon(1, out_vld1, {iv1, ovf1, inv1, inx1});
    end

    // Presents one operand until accepted; inputs change 1 time unit after
    // the rising edge, acceptance is decided from in_rdy at the falling edge.
    task automatic send(input logic [31:0] f);
        bit acc;
        in_vld = 1'b1;
        fp_val = f;
        for (int n = 0; n < 200; n++) begin
            if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_rdy0;
            if (acc) begin
                q0.push_back(model(f, 0));
                q1.push_back(model(f, 1));
                chk("in_rdy_match", 64'(in_rdy1), 64'(in_rdy0));
            end
            @(posedge clk);
            #1;
            if (acc) begin
                in_vld = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_rdy %b expected 1 within 200 cycles", in_rdy0);
        in_vld = 1'b0;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
    endtask

    logic [31:0] dir [20] = '{
        32'h3FC0_0000, 32'hC2F6_E979, 32'h4020_0000, 32'h3F00_0000, 32'hCF00_0000,
        32'h4F00_0000, 32'h4EFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h7FC0_0000,
        32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hBFC0_0000, 32'h3F40_0000,
        32'h4060_0000, 32'hCF00_0001, 32'hFFC0_0001, 32'h4B7F_FFFF, 32'h3EFF_FFFF
    };

    initial begin
        logic [31:0] f;
        rst     = 1'b1;
        in_vld  = 1'b0;
        fp_val  = '0;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out0", {27'd0, out_vld0, ovf0, inv0, inx0, iv0}, 64'd0);
        chk("reset_out1", {27'd0, out_vld1, ovf1, inv1, inx1, iv1}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_rdy", 64'({in_rdy0, in_rdy1}), 64'd3);
        @(posedge clk);
        #1;

        // Directed vectors, back to back with the consumer always ready.
        for (int i = 0; i < 20; i++) send(dir[i]);
        drain();

        // Randomized operands with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            f = $urandom();
            case ($urandom_range(0, 7))
                0:       f[30:23] = 8'h00;
                1:       f[30:23] = 8'hFF;
                2:       ;
                default: f[30:23] = 8'($urandom_range(100, 160));
            endcase
            send(f);
        end
        drain();

        // Backpressure: four values, consumer stalled for three cycles.
        out_rdy = 1'b0;
        fork
            begin
                send(32'h3F80_0000);
                send(32'h4000_0000);
                send(32'h4040_0000);
                send(32'h4080_0000);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_rdy_low", 64'({in_rdy0, in_rdy1}), 64'd0);
                @(posedge clk);
                #1 out_rdy = 1'b1;
            end
        join
        drain();

        // Reset with both stages occupied: held items must vanish.
        out_rdy = 1'b0;
        send(32'h40A0_0000);
        send(32'h40C0_0000);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_out_vld", 64'({out_vld0, out_vld1}), 64'd0);
        chk("rst_flush_in_rdy", 64'({in_rdy0, in_rdy1}), 64'd3);
        @(posedge clk);
        #1 out_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(32'h4100_0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
